// File: rtl/palette_lut_fader.sv
// Double-banked colour palette with a 2-stage lookup pipeline and a frame-stepped brightness fade.
// Host writes land in the shadow bank and are copied to the active bank at frame_start.
//
// fade state | meaning
// S_IDLE     | level matches the clamped target, frame counter held at 0
// S_COUNT    | level differs from target, counting frame_start pulses toward the next step
module palette_lut_fader #(
   parameter int IDX_W            = 4,
   parameter int CH_W             = 4,
   parameter int FADE_W           = 4,
   parameter int FADE_STEP_FRAMES = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                pix_valid,
   input  logic [IDX_W-1:0]    index,
   output logic [CH_W-1:0]     red,
   output logic [CH_W-1:0]     green,
   output logic [CH_W-1:0]     blue,
   output logic                out_valid,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_addr,
   input  logic [3*CH_W-1:0]   wr_data,
   input  logic                frame_start,
   input  logic [FADE_W:0]     fade_target,
   output logic [FADE_W:0]     fade_level,
   output logic                fade_busy,
   output logic                swap_pending
);

   localparam int DEPTH = 2**IDX_W;
   localparam int ENT_W = 3*CH_W;
   localparam int CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
   localparam logic [FADE_W:0] FULL    = (FADE_W+1)'(2**FADE_W);
   localparam logic [FADE_W:0] LVL_ONE = (FADE_W+1)'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES-1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {S_IDLE, S_COUNT} fade_state_e;

   logic [ENT_W-1:0]  shadow_q [DEPTH];
   logic [ENT_W-1:0]  shadow_d [DEPTH];
   logic [ENT_W-1:0]  active_q [DEPTH];
   logic [ENT_W-1:0]  active_d [DEPTH];
   logic              swap_pending_q, swap_pending_d;
   logic [ENT_W-1:0]  ent_q, ent_d;
   logic              v1_q, v1_d;
   logic [CH_W-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic              out_valid_q, out_valid_d;
   logic [FADE_W:0]   level_q, level_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   fade_state_e       state_q, state_d;
   logic [FADE_W:0]   target_c;

   // Product is wide enough to hold full-scale channel times full-scale level.
   function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] ch, input logic [FADE_W:0] lvl);
      logic [CH_W+FADE_W:0] prod;
      prod = {{(FADE_W+1){1'b0}}, ch} * {{CH_W{1'b0}}, lvl};
      return CH_W'(prod >> FADE_W);
   endfunction

   always_comb begin
      shadow_d       = shadow_q;
      active_d       = active_q;
      swap_pending_d = swap_pending_q;
      // Copy reads the registered shadow, so a coincident write waits for the next frame.
      if (frame_start && swap_pending_q) begin
         active_d       = shadow_q;
         swap_pending_d = 1'b0;
      end
      if (wr_en) begin
         shadow_d[wr_addr] = wr_data;
         swap_pending_d    = 1'b1;
      end
   end

   always_comb begin
      ent_d       = active_q[index];
      v1_d        = pix_valid;
      out_valid_d = v1_q;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
      if (v1_q) begin
         red_d   = scale(ent_q[ENT_W-1 -: CH_W], level_q);
         green_d = scale(ent_q[2*CH_W-1 -: CH_W], level_q);
         blue_d  = scale(ent_q[CH_W-1:0], level_q);
      end
   end

   always_comb begin
      target_c = (fade_target > FULL) ? FULL : fade_target;
      state_d  = state_q;
      level_d  = level_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (level_q != target_c) state_d = S_COUNT;
         end
         S_COUNT: begin
            if (level_q == target_c) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (frame_start) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  level_d = (target_c > level_q) ? level_q + LVL_ONE : level_q - LVL_ONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         shadow_q       <= '{default: '0};
         active_q       <= '{default: '0};
         swap_pending_q <= 1'b0;
         ent_q          <= '0;
         v1_q           <= 1'b0;
         red_q          <= '0;
         green_q        <= '0;
         blue_q         <= '0;
         out_valid_q    <= 1'b0;
         level_q        <= FULL;
         cnt_q          <= '0;
         state_q        <= S_IDLE;
      end else begin
         shadow_q       <= shadow_d;
         active_q       <= active_d;
         swap_pending_q <= swap_pending_d;
         ent_q          <= ent_d;
         v1_q           <= v1_d;
         red_q          <= red_d;
         green_q        <= green_d;
         blue_q         <= blue_d;
         out_valid_q    <= out_valid_d;
         level_q        <= level_d;
         cnt_q          <= cnt_d;
         state_q        <= state_d;
      end
   end

   assign red          = red_q;
   assign green        = green_q;
   assign blue         = blue_q;
   assign out_valid    = out_valid_q;
   assign fade_level   = level_q;
   assign fade_busy    = (level_q != target_c);
   assign swap_pending = swap_pending_q;

endmodule
